// File: rtl/soc_ctrl_seq_csr_pkg.sv
// Shared types and constants for the SoC control CSR block and its power sequencers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package soc_ctrl_pkg;

   typedef enum logic [2:0] {
      OFF,
      PLL_WAIT,
      CLK_ON,
      RUN,
      STOP,
      ERR
   } seq_state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // Register region, selected by addr[11:9]
   localparam logic [2:0] REG_BOOT     = 3'd0;  // 0x000
   localparam logic [2:0] REG_HART     = 3'd1;  // 0x200
   localparam logic [2:0] REG_CORE_FB  = 3'd2;  // 0x400
   localparam logic [2:0] REG_RAM_FB   = 3'd3;  // 0x600
   localparam logic [2:0] REG_TEMP_THR = 3'd5;  // 0xA00
   localparam logic [2:0] REG_TEMP     = 3'd6;  // 0xC00
   localparam logic [2:0] REG_MISC     = 3'd7;  // 0xE00

   // Index addr[8:3] inside the 0xE00 region
   localparam logic [5:0] IDX_CORE_LOCKED = 6'd0;
   localparam logic [5:0] IDX_RAM_LOCKED  = 6'd1;
   localparam logic [5:0] IDX_SEQ_UP      = 6'd2;
   localparam logic [5:0] IDX_SEQ_DOWN    = 6'd3;
   localparam logic [5:0] IDX_SEQ_RUN     = 6'd4;
   localparam logic [5:0] IDX_SEQ_ERR     = 6'd5;
   localparam logic [5:0] IDX_RAM_CTRL    = 6'd6;
   localparam logic [5:0] IDX_GLOB_ARST   = 6'd7;
   localparam logic [5:0] IDX_SYS_PLL_SEL = 6'd8;
   localparam logic [5:0] IDX_TEMP_ALARM  = 6'd9;

   // Byte-strobe merge of new write data into an old 64-bit register image
   function automatic logic [63:0] merge(input logic [63:0] old,
                                         input logic [63:0] wdata,
                                         input logic [7:0]  strb);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{strb[b]}};
      return (old & ~m) | (wdata & m);
   endfunction

endpackage

// File: rtl/soc_ctrl_seq_csr_if.sv
// Simple-memory CSR bus between the AXI converter (master) and the CSR block (slave).
// Latency: read data/response combinational with re; write response combinational with we.
// Backpressure: none, every strobe is accepted in its cycle.
// Signals: we/waddr/wdata/wstrb -> wresp ; re/raddr -> rdata/rresp.
interface soc_ctrl_seq_csr_if;
   logic        we;
   logic [11:0] waddr;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic [1:0]  wresp;
   logic        re;
   logic [11:0] raddr;
   logic [63:0] rdata;
   logic [1:0]  rresp;

   modport master (output we, waddr, wdata, wstrb, re, raddr,
                   input  wresp, rdata, rresp);
   modport slave  (input  we, waddr, wdata, wstrb, re, raddr,
                   output wresp, rdata, rresp);
endinterface

// File: rtl/soc_ctrl_seq_csr_core_pwr_seq.sv
// Per-core power sequencer: PLL lock wait with timeout, clock enable, then reset release; reverse on down.
// Latency: commands act on the next clock edge; clk_en/arst are decoded from the registered state.
// Backpressure: none; commands that do not apply to the current state are dropped.
// Ports: up/down/clr_err/force_off/locked in; clk_en, arst, state, err_set (one-cycle pulse) out.
module core_pwr_seq
   import soc_ctrl_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 4096,
   parameter int RST_HOLD_CYC = 16
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       up,
   input  logic       down,
   input  logic       clr_err,
   input  logic       force_off,
   input  logic       locked,
   output logic       clk_en,
   output logic       arst,
   output seq_state_e state,
   output logic       err_set
);

   localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD_CYC) ? LOCK_TIMEOUT : RST_HOLD_CYC;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD_CYC - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= OFF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         OFF: if (up) begin
            state_d = PLL_WAIT;
            cnt_d   = LOCK_LOAD;
         end
         PLL_WAIT: begin
            // Lock wins over a timeout expiring in the same cycle
            if (locked) begin
               state_d = CLK_ON;
               cnt_d   = HOLD_LOAD;
            end else if (cnt_q == '0) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         CLK_ON: if (cnt_q == '0) state_d = RUN; else cnt_d = cnt_q - ONE;
         RUN: if (down) begin
            state_d = STOP;
            cnt_d   = HOLD_LOAD;
         end
         STOP: if (cnt_q == '0) state_d = OFF; else cnt_d = cnt_q - ONE;
         ERR: if (clr_err) state_d = OFF;
         default: state_d = OFF;
      endcase
      if (force_off) state_d = OFF;
   end

   always_comb begin
      clk_en  = (state_q == CLK_ON) || (state_q == RUN) || (state_q == STOP);
      arst    = (state_q != RUN);
      // Lock timeout and lock loss while running both flag the error; RUN is kept on lock loss
      err_set = ((state_q == PLL_WAIT) && !locked && (cnt_q == '0)) ||
                ((state_q == RUN) && !locked);
   end

   assign state = state_q;

endmodule

// File: rtl/soc_ctrl_seq_csr.sv
// SoC control CSRs: per-core boot/hart/PLL divider, RAM/global control, per-core power sequencers.
// Latency: reads combinational with re; writes land on the next clk_i edge; temp_irq_o one extra cycle.
// Backpressure: none; bad accesses complete immediately with SLVERR and no side effects.
// Ports: clk_i, arst_i (async, active-high), mem (CSR bus slave), per-core vectors, RAM/global controls.
// Optional: define SOC_CTRL_TEMP_ALARM_EN for temperature thresholds, TEMP_ALARM and temp_irq_o.
module soc_ctrl_seq_csr
   import soc_ctrl_pkg::*;
#(
   parameter int          NUM_CORE          = 4,
   parameter int          XLEN              = 64,
   parameter int          FB_DIV_WIDTH      = 12,
   parameter int          TEMP_SENSOR_WIDTH = 10,
   parameter logic [63:0] BOOT_ADDR_RST     = 64'h0,
   parameter int          LOCK_TIMEOUT      = 4096,
   parameter int          RST_HOLD_CYC      = 16
) (
   input  logic                                  clk_i,
   input  logic                                  arst_i,
   soc_ctrl_seq_csr_if.slave                     mem,
   output logic [NUM_CORE*XLEN-1:0]              boot_addr_vec_o,
   output logic [NUM_CORE*XLEN-1:0]              hart_id_vec_o,
   output logic [NUM_CORE-1:0]                   core_clk_en_vec_o,
   output logic [NUM_CORE-1:0]                   core_arst_vec_o,
   output logic [NUM_CORE*FB_DIV_WIDTH-1:0]      core_pll_fb_div_vec_o,
   input  logic [NUM_CORE-1:0]                   core_pll_locked_i,
   input  logic [NUM_CORE*TEMP_SENSOR_WIDTH-1:0] core_temp_sensor_vec_i,
   output logic                                  ram_clk_en_o,
   output logic                                  ram_arst_o,
   output logic [FB_DIV_WIDTH-1:0]               ram_pll_fb_div_o,
   input  logic                                  ram_pll_locked_i,
   output logic                                  glob_arst_o,
   input  logic [$clog2(NUM_CORE+1)-1:0]         sys_pll_select_i,
   output logic                                  temp_irq_o
);

   localparam int TW = TEMP_SENSOR_WIDTH;

   logic [XLEN-1:0]         boot_q [NUM_CORE];
   logic [XLEN-1:0]         hart_q [NUM_CORE];
   logic [FB_DIV_WIDTH-1:0] fb_q   [NUM_CORE];
   logic [FB_DIV_WIDTH-1:0] ram_fb_q;
   logic                    ram_clk_en_q, ram_arst_q, glob_arst_q;
   logic [NUM_CORE-1:0]     err_q, err_set, up_v, down_v, clr_v, busy_v, run_v, cmd_bits;
   seq_state_e              seq_st [NUM_CORE];

   logic [2:0]  wreg, rreg;
   logic [5:0]  widx, ridx;
   logic        widx_ok, ridx_ok, fb_idle, w_ok, wr, rd_ok;
   logic [63:0] rd_dat, ram_ctrl_m, glob_m, ram_fb_m;
   logic        unused_addr_bits;

   assign wreg    = mem.waddr[11:9];
   assign widx    = mem.waddr[8:3];
   assign rreg    = mem.raddr[11:9];
   assign ridx    = mem.raddr[8:3];
   assign widx_ok = int'(widx) < NUM_CORE;
   assign ridx_ok = int'(ridx) < NUM_CORE;
   // Registers are 8-byte aligned; the byte offset inside a register does not select anything
   assign unused_addr_bits = ^{mem.waddr[2:0], mem.raddr[2:0]};

   // ---------------- write decode ----------------
   always_comb begin
      fb_idle = 1'b0;
      for (int i = 0; i < NUM_CORE; i++)
         if (int'(widx) == i) fb_idle = (seq_st[i] == OFF);
      w_ok = 1'b0;
      case (wreg)
         REG_BOOT, REG_HART: w_ok = widx_ok;
         REG_CORE_FB:        w_ok = widx_ok && fb_idle;  // divider locked while sequencer active
         REG_RAM_FB:         w_ok = (widx == '0);
`ifdef SOC_CTRL_TEMP_ALARM_EN
         REG_TEMP_THR:       w_ok = widx_ok;
`endif
         REG_MISC: begin
            case (widx)
               IDX_SEQ_UP, IDX_SEQ_DOWN, IDX_SEQ_ERR,
               IDX_RAM_CTRL, IDX_GLOB_ARST: w_ok = 1'b1;
`ifdef SOC_CTRL_TEMP_ALARM_EN
               IDX_TEMP_ALARM:              w_ok = 1'b1;
`endif
               default:                     w_ok = 1'b0;
            endcase
         end
         default: w_ok = 1'b0;
      endcase
   end

   assign wr        = mem.we && w_ok;
   assign mem.wresp = (mem.we && !w_ok) ? SLVERR : OKAY;

   // Strobe-qualified command bits for WO1/W1C registers
   always_comb begin
      for (int i = 0; i < NUM_CORE; i++) cmd_bits[i] = mem.wdata[i] & mem.wstrb[i/8];
   end

   assign up_v   = (wr && wreg == REG_MISC && widx == IDX_SEQ_UP)   ? cmd_bits : '0;
   assign down_v = (wr && wreg == REG_MISC && widx == IDX_SEQ_DOWN) ? cmd_bits : '0;
   assign clr_v  = (wr && wreg == REG_MISC && widx == IDX_SEQ_ERR)  ? cmd_bits : '0;

   assign ram_ctrl_m = merge({62'd0, ram_arst_q, ram_clk_en_q}, mem.wdata, mem.wstrb);
   assign glob_m     = merge({63'd0, glob_arst_q}, mem.wdata, mem.wstrb);
   assign ram_fb_m   = merge(64'(ram_fb_q), mem.wdata, mem.wstrb);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int i = 0; i < NUM_CORE; i++) begin
            boot_q[i] <= XLEN'(BOOT_ADDR_RST);
            hart_q[i] <= XLEN'(i);
            fb_q[i]   <= '0;
         end
         ram_fb_q     <= '0;
         ram_clk_en_q <= 1'b0;
         ram_arst_q   <= 1'b1;
         glob_arst_q  <= 1'b0;
         err_q        <= '0;
      end else begin
         for (int i = 0; i < NUM_CORE; i++) begin
            if (wr && int'(widx) == i) begin
               if (wreg == REG_BOOT)
                  boot_q[i] <= XLEN'(merge(64'(boot_q[i]), mem.wdata, mem.wstrb));
               if (wreg == REG_HART)
                  hart_q[i] <= XLEN'(merge(64'(hart_q[i]), mem.wdata, mem.wstrb));
               if (wreg == REG_CORE_FB)
                  fb_q[i] <= FB_DIV_WIDTH'(merge(64'(fb_q[i]), mem.wdata, mem.wstrb));
            end
         end
         if (wr && wreg == REG_RAM_FB) ram_fb_q <= FB_DIV_WIDTH'(ram_fb_m);
         if (wr && wreg == REG_MISC && widx == IDX_RAM_CTRL) begin
            ram_clk_en_q <= ram_ctrl_m[0];
            ram_arst_q   <= ram_ctrl_m[1];
         end
         if (wr && wreg == REG_MISC && widx == IDX_GLOB_ARST) glob_arst_q <= glob_m[0];
         // A new error in the same cycle as its clear survives
         err_q <= (err_q & ~clr_v) | err_set;
      end
   end

   // ---------------- sequencers ----------------
   for (genvar i = 0; i < NUM_CORE; i++) begin : g_core
      core_pwr_seq #(
         .LOCK_TIMEOUT (LOCK_TIMEOUT),
         .RST_HOLD_CYC (RST_HOLD_CYC)
      ) u_seq (
         .clk_i     (clk_i),
         .arst_i    (arst_i),
         .up        (up_v[i]),
         .down      (down_v[i]),
         .clr_err   (clr_v[i]),
         .force_off (glob_arst_q),
         .locked    (core_pll_locked_i[i]),
         .clk_en    (core_clk_en_vec_o[i]),
         .arst      (core_arst_vec_o[i]),
         .state     (seq_st[i]),
         .err_set   (err_set[i])
      );
      assign busy_v[i] = !((seq_st[i] == OFF) || (seq_st[i] == RUN));
      assign run_v[i]  = (seq_st[i] == RUN);
      assign boot_addr_vec_o[i*XLEN +: XLEN]                = boot_q[i];
      assign hart_id_vec_o[i*XLEN +: XLEN]                  = hart_q[i];
      assign core_pll_fb_div_vec_o[i*FB_DIV_WIDTH +: FB_DIV_WIDTH] = fb_q[i];
   end

   assign ram_clk_en_o     = ram_clk_en_q;
   assign ram_arst_o       = ram_arst_q;
   assign ram_pll_fb_div_o = ram_fb_q;
   assign glob_arst_o      = glob_arst_q;

   // ---------------- temperature alarm ----------------
`ifdef SOC_CTRL_TEMP_ALARM_EN
   logic [TW-1:0]       thr_q [NUM_CORE];
   logic [NUM_CORE-1:0] alarm_q, alarm_hit, alarm_clr;
   logic                irq_q;

   always_comb begin
      for (int i = 0; i < NUM_CORE; i++)
         alarm_hit[i] = core_temp_sensor_vec_i[i*TW +: TW] > thr_q[i];
   end

   assign alarm_clr = (wr && wreg == REG_MISC && widx == IDX_TEMP_ALARM) ? cmd_bits : '0;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int i = 0; i < NUM_CORE; i++) thr_q[i] <= '1;
         alarm_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CORE; i++)
            if (wr && wreg == REG_TEMP_THR && int'(widx) == i)
               thr_q[i] <= TW'(merge(64'(thr_q[i]), mem.wdata, mem.wstrb));
         alarm_q <= (alarm_q & ~alarm_clr) | alarm_hit;  // set beats clear
         irq_q   <= |alarm_q;
      end
   end

   assign temp_irq_o = irq_q;
`else
   assign temp_irq_o = 1'b0;
`endif

   // ---------------- read path ----------------
   always_comb begin
      rd_dat = '0;
      rd_ok  = 1'b0;
      case (rreg)
         REG_BOOT: for (int i = 0; i < NUM_CORE; i++)
            if (int'(ridx) == i) begin rd_dat = 64'(boot_q[i]); rd_ok = 1'b1; end
         REG_HART: for (int i = 0; i < NUM_CORE; i++)
            if (int'(ridx) == i) begin rd_dat = 64'(hart_q[i]); rd_ok = 1'b1; end
         REG_CORE_FB: for (int i = 0; i < NUM_CORE; i++)
            if (int'(ridx) == i) begin rd_dat = 64'(fb_q[i]); rd_ok = 1'b1; end
         REG_RAM_FB: if (ridx == '0) begin rd_dat = 64'(ram_fb_q); rd_ok = 1'b1; end
`ifdef SOC_CTRL_TEMP_ALARM_EN
         REG_TEMP_THR: for (int i = 0; i < NUM_CORE; i++)
            if (int'(ridx) == i) begin rd_dat = 64'(thr_q[i]); rd_ok = 1'b1; end
`endif
         REG_TEMP: for (int i = 0; i < NUM_CORE; i++)
            if (int'(ridx) == i) begin
               rd_dat = 64'(core_temp_sensor_vec_i[i*TW +: TW]);
               rd_ok  = 1'b1;
            end
         REG_MISC: begin
            rd_ok = 1'b1;
            case (ridx)
               IDX_CORE_LOCKED: rd_dat = 64'(core_pll_locked_i);
               IDX_RAM_LOCKED:  rd_dat = 64'(ram_pll_locked_i);
               IDX_SEQ_UP:      rd_dat = 64'(busy_v);
               IDX_SEQ_DOWN:    rd_dat = '0;
               IDX_SEQ_RUN:     rd_dat = 64'(run_v);
               IDX_SEQ_ERR:     rd_dat = 64'(err_q);
               IDX_RAM_CTRL:    rd_dat = {62'd0, ram_arst_q, ram_clk_en_q};
               IDX_GLOB_ARST:   rd_dat = {63'd0, glob_arst_q};
               IDX_SYS_PLL_SEL: rd_dat = 64'(sys_pll_select_i);
`ifdef SOC_CTRL_TEMP_ALARM_EN
               IDX_TEMP_ALARM:  rd_dat = 64'(alarm_q);
`endif
               default:         rd_ok = 1'b0;
            endcase
         end
         default: rd_ok = 1'b0;
      endcase
   end

   assign mem.rdata = mem.re ? rd_dat : '0;
   assign mem.rresp = (mem.re && !rd_ok) ? SLVERR : OKAY;

endmodule
